schwap_ctrl: RTL and testbench
==============================

SCHWAP_CTRL -- requirements
Module: schwap_ctrl

Interface
REQ-001 SHALL have parameter BANKS, default 16, number of register banks (power of two).
REQ-002 SHALL have parameter BANK_W, default 4, equal to log2(BANKS).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmdValid  input  1  command offered.
REQ-006 SHALL have port cmdOp  input  2  opcode: 01 CALL, 10 RET, 11 SET, 00 NOP.
REQ-007 SHALL have port cmdBank  input  BANK_W  target bank for CALL/SET.
REQ-008 SHALL have port cmdReady  output  1  command accepted when cmdValid&cmdReady.
REQ-009 SHALL have port schwapReg  output  BANK_W  bank index driven to register file.
REQ-010 SHALL have port schwapClk  output  1  one-cycle latch strobe for schwapReg.
REQ-011 SHALL have port busy  output  1  bank switch in progress; pipeline stalls reg-file access.
REQ-012 SHALL have port depth  output  BANK_W+1  current return-stack occupancy, 0..BANKS.
REQ-013 SHALL have port errClr  input  1  clears sticky error flags.
REQ-014 SHALL have port ovf  output  1  sticky: CALL attempted with full stack.
REQ-015 SHALL have port unf  output  1  sticky: RET attempted with empty stack.

Function
REQ-016 SHALL implement FSM IDLE -> STROBE -> SETTLE -> IDLE; cmdReady=1 only in IDLE; busy=1 in STROBE and SETTLE.
REQ-017 SHALL, on accepted CALL with depth<BANKS: push current schwapReg, depth+1, next schwapReg=cmdBank, go STROBE.
REQ-018 SHALL, on accepted RET with depth>0: pop top into schwapReg, depth-1, go STROBE.
REQ-019 SHALL, on accepted SET: schwapReg=cmdBank, stack/depth unchanged, go STROBE.
REQ-020 SHALL treat accepted NOP as no-op, remaining IDLE, no strobe.
REQ-021 SHALL, on CALL with depth==BANKS: consume command, no push, no bank change, set ovf, stay IDLE.
REQ-022 SHALL, on RET with depth==0: consume command, no pop, no bank change, set unf, stay IDLE.
REQ-023 SHALL register schwapReg so it is stable one full cycle before and during the schwapClk high cycle.
REQ-024 SHALL drive schwapClk high exactly during STROBE (cycle N+1 after acceptance in cycle N), from a flop, glitch-free.
REQ-025 SHALL return to IDLE at cycle N+3; back-to-back commands accepted every 3 cycles.
REQ-026 SHALL give set priority over errClr when both occur in the same cycle.
REQ-027 SHALL permit SET to the current bank; still strobes.
REQ-028 SHALL ignore cmdValid/cmdOp/cmdBank outside IDLE.

Reset
REQ-029 SHALL, when rst_n low, asynchronously force: FSM IDLE, schwapReg=0, schwapClk=0, busy=0, cmdReady=1, depth=0, ovf=0, unf=0.
REQ-030 SHALL abort an in-flight strobe on reset mid-operation; no partial update persists.
REQ-031 SHALL leave stack storage unreset; contents irrelevant because depth=0.

Structure
REQ-032 SHALL place opcode constants, BANKS, BANK_W in shared header schwap_defs, also used by the register file.
REQ-033 SHALL instantiate one sub-module schwap_stack: BANKS x BANK_W LIFO, push/pop/top, synchronous write, combinational top.

Verification
REQ-034 SHALL test reset: release rst_n -> schwapReg=0, depth=0, cmdReady=1, schwapClk=0.
REQ-035 SHALL test CALL 5 then RET: CALL at cycle 0 -> schwapReg=5 and schwapClk=1 at cycle 1, cmdReady=1 at cycle 3, depth=1; RET -> schwapReg=0, depth=0.
REQ-036 SHALL test overflow: 16 CALLs (banks 1..15,0) then 17th CALL 7 -> depth=16, ovf=1, schwapReg unchanged, no strobe.
REQ-037 SHALL test underflow then clear: RET at depth 0 -> unf=1; errClr -> unf=0; errClr with a new RET underflow in the same cycle -> unf=1.
REQ-038 SHALL test busy gating: SET 9, then CALL 3 held valid -> CALL accepted only at cycle 3, schwapReg=3 at cycle 4, stack top=9.
REQ-039 SHALL test reset mid-strobe: assert rst_n low during STROBE -> schwapClk=0 and schwapReg=0 immediately.

Source files
------------

// File: rtl/schwap_ctrl_pkg.sv
// Shared definitions for the register-bank switch controller and the
// register file it drives: bank geometry, command opcodes, FSM states.
package schwap_ctrl_pkg;

  localparam int BANKS  = 16;
  localparam int BANK_W = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_SET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STROBE = 2'b01,
    ST_SETTLE = 2'b10
  } state_e;

endpackage

// File: rtl/schwap_ctrl_if.sv
// Command handshake bundle for schwap_ctrl.
//   cmdValid : command offered            (master -> slave)
//   cmdOp    : opcode (NOP/CALL/RET/SET)  (master -> slave)
//   cmdBank  : target bank for CALL/SET   (master -> slave)
//   cmdReady : command taken when valid&ready (slave -> master)
interface schwap_ctrl_if #(
  parameter int BANK_W = schwap_ctrl_pkg::BANK_W
) ();
  logic              cmdValid;
  logic [1:0]        cmdOp;
  logic [BANK_W-1:0] cmdBank;
  logic              cmdReady;

  modport master (output cmdValid, cmdOp, cmdBank, input  cmdReady);
  modport slave  (input  cmdValid, cmdOp, cmdBank, output cmdReady);
endinterface

// File: rtl/schwap_ctrl_stack.sv
// Return-bank LIFO: BANKS entries of BANK_W bits.
//   push/din : write din at the current occupancy, occupancy+1 (ignored when full)
//   pop      : occupancy-1 (ignored when empty)
//   top      : combinational view of the most recent entry
//   depth    : occupancy 0..BANKS; full/empty derived from it
// Storage is not reset; only the occupancy counter is, so stale entries
// are never visible.
module schwap_stack #(
  parameter int BANKS  = 16,
  parameter int BANK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BANK_W-1:0] din,
  output logic [BANK_W-1:0] top,
  output logic [BANK_W:0]   depth,
  output logic              full,
  output logic              empty
);
  logic [BANK_W-1:0] mem [BANKS];
  logic [BANK_W-1:0] wr_idx;
  logic [BANK_W-1:0] top_idx;

  assign wr_idx  = depth[BANK_W-1:0];
  // Wraps to BANKS-1 when full, which is exactly the top slot.
  assign top_idx = depth[BANK_W-1:0] - {{(BANK_W-1){1'b0}}, 1'b1};
  // BANKS is a power of two and depth never exceeds it, so the MSB means full.
  assign full    = depth[BANK_W];
  assign empty   = (depth == '0);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                depth <= '0;
    else if (push && !full)    depth <= depth + 1'b1;
    else if (pop && !empty)    depth <= depth - 1'b1;
  end
endmodule

// File: rtl/schwap_ctrl.sv
// Register-bank switch controller. Accepts CALL/RET/SET/NOP commands,
// keeps a return stack of bank indices and drives the register file's
// bank select with a one-cycle latch strobe.
//   clk, rst_n : clock, async active-low reset
//   cmd        : command handshake (slave side)
//   schwapReg  : registered bank index to the register file
//   schwapClk  : registered one-cycle latch strobe
//   busy       : switch in progress (STROBE/SETTLE)
//   depth      : return-stack occupancy 0..BANKS
//   errClr     : clears sticky ovf/unf (a same-cycle new error wins)
//   ovf, unf   : sticky CALL-on-full / RET-on-empty flags
module schwap_ctrl #(
  parameter int BANKS  = schwap_ctrl_pkg::BANKS,
  parameter int BANK_W = schwap_ctrl_pkg::BANK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  schwap_ctrl_if.slave      cmd,
  output logic [BANK_W-1:0] schwapReg,
  output logic              schwapClk,
  output logic              busy,
  output logic [BANK_W:0]   depth,
  input  logic              errClr,
  output logic              ovf,
  output logic              unf
);
  import schwap_ctrl_pkg::*;

  state_e            state;
  op_e               op;
  logic              rdy;
  logic              accept;
  logic              push, pop, set_op;
  logic              go;
  logic              ovf_set, unf_set;
  logic              full, empty;
  logic [BANK_W-1:0] top;

  assign op           = op_e'(cmd.cmdOp);
  // Inputs are only looked at while IDLE; everything else is ignored.
  assign accept       = (state == ST_IDLE) && cmd.cmdValid;
  assign push         = accept && (op == OP_CALL) && !full;
  assign pop          = accept && (op == OP_RET)  && !empty;
  assign set_op       = accept && (op == OP_SET);
  assign ovf_set      = accept && (op == OP_CALL) && full;
  assign unf_set      = accept && (op == OP_RET)  && empty;
  assign go           = push || pop || set_op;
  assign cmd.cmdReady = rdy;

  // The stack captures the outgoing bank on CALL, before schwapReg changes.
  schwap_stack #(.BANKS(BANKS), .BANK_W(BANK_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (schwapReg),
    .top   (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      schwapReg <= '0;
      schwapClk <= 1'b0;
      busy      <= 1'b0;
      rdy       <= 1'b1;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      // A new error in the same cycle as errClr stays set.
      ovf <= ovf_set | (ovf & ~errClr);
      unf <= unf_set | (unf & ~errClr);
      case (state)
        ST_IDLE: begin
          if (go) begin
            schwapReg <= pop ? top : cmd.cmdBank;
            schwapClk <= 1'b1;
            busy      <= 1'b1;
            rdy       <= 1'b0;
            state     <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          schwapClk <= 1'b0;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          busy  <= 1'b0;
          rdy   <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          schwapClk <= 1'b0;
          busy      <= 1'b0;
          rdy       <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_schwap_ctrl.sv
// Self-checking bench for schwap_ctrl: directed table, hand-written
// timing sequences and a randomized run against a queue-based model.
module tb_schwap_ctrl;
  localparam logic [1:0] NOP = 2'b00, CALL = 2'b01, RET = 2'b10, SET = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       errClr = 1'b0;
  logic [3:0] schwapReg;
  logic       schwapClk, busy, ovf, unf;
  logic [4:0] depth;
  int         checks = 0;
  int         errors = 0;

  // Reference model: the return stack as a queue, current bank, sticky flags.
  int         mstk[$];
  int         mbank;
  bit         movf, munf;

  schwap_ctrl_if #(.BANK_W(4)) cif ();

  schwap_ctrl #(.BANKS(16), .BANK_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .schwapReg (schwapReg),
    .schwapClk (schwapClk),
    .busy      (busy),
    .depth     (depth),
    .errClr    (errClr),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cif.cmdValid = 1'b0; cif.cmdOp = NOP; cif.cmdBank = '0; errClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg", schwapReg, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ready", cif.cmdReady, 1);
    chk("rst_clk", schwapClk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {ovf, unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mstk.delete(); mbank = 0; movf = 0; munf = 0;
  endtask

  // Issue one command once ready, update the model, check the acceptance
  // cycle and (for switching commands) the STROBE/SETTLE/IDLE timing.
  task automatic apply(input logic [1:0] op, input int bank, input bit ec,
                       output int c_reg, output int c_depth,
                       output int c_clk, output int c_unf);
    int n = 0;
    bit strobe = 0, os = 0, us = 0;
    logic [3:0] b4;
    @(negedge clk);
    while (!cif.cmdReady && n < 20) begin @(negedge clk); n++; end
    if (!cif.cmdReady) chk("ready_timeout", 0, 1);
    b4 = bank[3:0];
    cif.cmdValid = 1'b1; cif.cmdOp = op; cif.cmdBank = b4; errClr = ec;
    case (op)
      CALL: if (mstk.size() == 16) os = 1;
            else begin mstk.push_back(mbank); mbank = bank % 16; strobe = 1; end
      RET:  if (mstk.size() == 0) us = 1;
            else begin mbank = mstk.pop_back(); strobe = 1; end
      SET:  begin mbank = bank % 16; strobe = 1; end
      default: ;
    endcase
    movf = os | (movf & ~ec);
    munf = us | (munf & ~ec);
    @(posedge clk);
    #1;
    cif.cmdValid = 1'b0; errClr = 1'b0;
    c_reg = schwapReg; c_depth = depth; c_clk = schwapClk; c_unf = unf;
    chk("acc_reg", schwapReg, mbank);
    chk("acc_depth", depth, mstk.size());
    chk("acc_clk", schwapClk, strobe);
    chk("acc_flags", {ovf, unf}, {movf, munf});
    chk("acc_ready", cif.cmdReady, !strobe);
    if (strobe) begin
      @(posedge clk); #1;
      chk("settle_clk_busy", {schwapClk, busy, cif.cmdReady}, 3'b010);
      @(posedge clk); #1;
      chk("idle_ready_busy", {cif.cmdReady, busy}, 2'b10);
    end
  endtask

  typedef struct {
    logic [1:0] op; int bank; bit ec;
    int e_reg; int e_depth; int e_clk; int e_unf;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int r, d, c, u, opsel;
    logic [1:0] rop;
    tbl[0] = '{CALL, 5,  0, 5,  1, 1, 0};
    tbl[1] = '{RET,  0,  0, 0,  0, 1, 0};
    tbl[2] = '{RET,  0,  0, 0,  0, 0, 1};
    tbl[3] = '{NOP,  0,  1, 0,  0, 0, 0};
    tbl[4] = '{SET,  3,  0, 3,  0, 1, 0};
    tbl[5] = '{SET,  3,  0, 3,  0, 1, 0};
    tbl[6] = '{CALL, 10, 0, 10, 1, 1, 0};
    tbl[7] = '{RET,  0,  0, 3,  0, 1, 0};
    tbl[8] = '{RET,  0,  1, 3,  0, 0, 1};
    tbl[9] = '{NOP,  0,  1, 3,  0, 0, 0};

    cif.cmdValid = 1'b0; cif.cmdOp = NOP; cif.cmdBank = '0;
    do_reset();

    // Directed table
    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].bank, tbl[i].ec, r, d, c, u);
      chk($sformatf("tbl%0d_reg", i), r, tbl[i].e_reg);
      chk($sformatf("tbl%0d_depth", i), d, tbl[i].e_depth);
      chk($sformatf("tbl%0d_clk", i), c, tbl[i].e_clk);
      chk($sformatf("tbl%0d_unf", i), u, tbl[i].e_unf);
    end

    // Overflow: 16 CALLs fill the stack, the 17th is consumed with no switch
    do_reset();
    for (int i = 1; i <= 16; i++) apply(CALL, i % 16, 0, r, d, c, u);
    apply(CALL, 7, 0, r, d, c, u);
    chk("ovf_depth", d, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_reg", r, 0);
    chk("ovf_nostrobe", c, 0);

    // Busy gating: CALL 3 held valid behind SET 9 is taken only at cycle 3
    do_reset();
    @(negedge clk);
    cif.cmdValid = 1'b1; cif.cmdOp = SET; cif.cmdBank = 4'd9;
    @(posedge clk); #1;
    chk("gate_c1", {schwapClk, schwapReg}, {1'b1, 4'd9});
    @(negedge clk);
    cif.cmdOp = CALL; cif.cmdBank = 4'd3;
    @(posedge clk); #1;
    chk("gate_c2", {cif.cmdReady, schwapReg}, {1'b0, 4'd9});
    @(posedge clk); #1;
    chk("gate_c3", {cif.cmdReady, schwapReg, depth}, {1'b1, 4'd9, 5'd0});
    @(posedge clk); #1;
    chk("gate_c4", {schwapClk, schwapReg, depth}, {1'b1, 4'd3, 5'd1});
    cif.cmdValid = 1'b0;
    mstk.push_back(9); mbank = 3;
    repeat (2) @(posedge clk);
    #1;
    apply(RET, 0, 0, r, d, c, u);
    chk("gate_top", r, 9);

    // Reset during STROBE aborts everything at once
    do_reset();
    apply(CALL, 4, 0, r, d, c, u);
    @(negedge clk);
    cif.cmdValid = 1'b1; cif.cmdOp = SET; cif.cmdBank = 4'd6;
    @(posedge clk); #1;
    cif.cmdValid = 1'b0;
    chk("mid_strobe", {schwapClk, schwapReg}, {1'b1, 4'd6});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", schwapClk, 0);
    chk("mid_rst_reg", schwapReg, 0);
    chk("mid_rst_state", {depth, cif.cmdReady, busy}, {5'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    mstk.delete(); mbank = 0; movf = 0; munf = 0;
    apply(RET, 0, 0, r, d, c, u);
    chk("mid_rst_unf", u, 1);

    // Randomized run: CALL-heavy phase, then RET-heavy phase
    do_reset();
    for (int i = 0; i < 300; i++) begin
      opsel = $urandom_range(0, 9);
      if (i < 150) rop = (opsel < 6) ? CALL : (opsel < 8) ? SET : (opsel < 9) ? RET : NOP;
      else         rop = (opsel < 6) ? RET  : (opsel < 8) ? SET : (opsel < 9) ? CALL : NOP;
      apply(rop, $urandom_range(0, 15), ($urandom_range(0, 4) == 0), r, d, c, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
